hzd: RTL and testbench



---
 rtl/ecap5_dproc_pkg.sv | 16 +
 rtl/hzd_scoreboard.sv | 59 +++++
 rtl/hzd.sv | 173 +++++++++++++++++
 tb/tb_hzd.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ecap5_dproc_pkg.sv
// -----------------------------------------------------------------------------
// ecap5_dproc_pkg
// Shared types and constants for the data-processor pipeline control blocks.
//   hzd_state_t         : issue-controller state (normal issue / fetch-decode flush)
//   HZD_FLUSH_LEN_MAX   : largest flush length the 4-bit flush counter can hold
// -----------------------------------------------------------------------------
package ecap5_dproc_pkg;

  typedef enum logic {
    HZD_RUN   = 1'b0,
    HZD_FLUSH = 1'b1
  } hzd_state_t;

  localparam int HZD_FLUSH_LEN_MAX = 15;

endpackage : ecap5_dproc_pkg

// File: rtl/hzd_scoreboard.sv
// -----------------------------------------------------------------------------
// hzd_scoreboard
// One pending bit per architectural register for writes that have issued but
// not yet retired through writeback. x0 is never marked pending.
//
// Ports
//   clk_i       in   clock, rising edge
//   rst_i       in   synchronous active-low reset, clears every pending bit
//   set_en_i    in   mark set_addr_i pending (issue of a register write)
//   set_addr_i  in   [4:0] register being claimed
//   clr_en_i    in   retire clr_addr_i (writeback commit)
//   clr_addr_i  in   [4:0] register being retired
//   sb_eff_o    out  [31:0] pending view with this cycle's writeback already
//                    removed, matching a write-first register file
// -----------------------------------------------------------------------------
module hzd_scoreboard
  import ecap5_dproc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        set_en_i,
  input  logic [4:0]  set_addr_i,
  input  logic        clr_en_i,
  input  logic [4:0]  clr_addr_i,
  output logic [31:0] sb_eff_o
);

  logic [31:0] r_sb;
  logic [31:0] w_set_mask;
  logic [31:0] w_clr_mask;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (set_en_i && (set_addr_i != 5'd0)) begin
      w_set_mask[set_addr_i] = 1'b1;
    end
    if (clr_en_i) begin
      w_clr_mask[clr_addr_i] = 1'b1;
    end
  end

  // Clear is applied before set so a same-cycle set/clear of one index
  // leaves the register pending: the new writer has not retired yet.
  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_sb <= '0;
    end else begin
      r_sb <= (r_sb & ~w_clr_mask) | w_set_mask;
    end
  end

  assign sb_eff_o = r_sb & ~w_clr_mask;

endmodule : hzd_scoreboard

// File: rtl/hzd.sv
// -----------------------------------------------------------------------------
// hzd
// Hazard / issue controller for the execute stage. Each cycle it decides
// whether the decoded instruction issues, stalls decode on RAW/WAW hazards
// against in-flight writes, and flushes fetch/decode for FLUSH_LEN cycles
// after execute reports a taken branch.
//
// Parameters
//   FLUSH_LEN        cycles flush_o stays high after a taken branch (1..15)
//
// Ports
//   clk_i            in   clock, rising edge
//   rst_i            in   synchronous active-low reset
//   dec_valid_i      in   decode presents an instruction
//   dec_rs1_used_i   in   instruction reads rs1
//   dec_rs1_addr_i   in   [4:0] rs1 index
//   dec_rs2_used_i   in   instruction reads rs2
//   dec_rs2_addr_i   in   [4:0] rs2 index
//   dec_rd_write_i   in   instruction writes rd
//   dec_rd_addr_i    in   [4:0] rd index
//   exm_ready_i      in   execute can accept an instruction
//   exm_valid_o      out  issue strobe into execute (combinational)
//   dec_stall_o      out  decode must hold its instruction
//   branch_i         in   taken branch, qualified by exm_out_valid_i
//   exm_out_valid_i  in   execute output valid
//   wb_write_i       in   writeback commits a register
//   wb_addr_i        in   [4:0] writeback index
//   flush_o          out  invalidate fetch and decode (registered, Moore)
//   stall_count_o    out  [31:0] saturating stall-cycle counter   (optional)
//   flush_count_o    out  [31:0] saturating flush start/reload count (optional)
//
// Build option
//   HZD_PERF_COUNTERS_EN  define to add stall_count_o / flush_count_o.
// -----------------------------------------------------------------------------
module hzd
  import ecap5_dproc_pkg::*;
#(
  parameter int FLUSH_LEN = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dec_valid_i,
  input  logic        dec_rs1_used_i,
  input  logic [4:0]  dec_rs1_addr_i,
  input  logic        dec_rs2_used_i,
  input  logic [4:0]  dec_rs2_addr_i,
  input  logic        dec_rd_write_i,
  input  logic [4:0]  dec_rd_addr_i,
  input  logic        exm_ready_i,
  output logic        exm_valid_o,
  output logic        dec_stall_o,
  input  logic        branch_i,
  input  logic        exm_out_valid_i,
  input  logic        wb_write_i,
  input  logic [4:0]  wb_addr_i,
  output logic        flush_o
`ifdef HZD_PERF_COUNTERS_EN
  ,
  output logic [31:0] stall_count_o,
  output logic [31:0] flush_count_o
`endif
);

  // FLUSH_LEN must lie in 1..HZD_FLUSH_LEN_MAX so the reload fits in 4 bits.
  localparam logic [3:0] CNT_RELOAD = 4'(FLUSH_LEN - 1);

  hzd_state_t  r_state;
  hzd_state_t  w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;

  logic [31:0] w_sb_eff;
  logic        w_hazard;
  logic        w_taken;
  logic        w_issue;

  // ---------------------------------------------------------------------------
  // Scoreboard: claimed on issue of a non-x0 write, retired by writeback.
  // ---------------------------------------------------------------------------
  hzd_scoreboard u_sb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set_en_i   (w_issue & dec_rd_write_i),
    .set_addr_i (dec_rd_addr_i),
    .clr_en_i   (wb_write_i),
    .clr_addr_i (wb_addr_i),
    .sb_eff_o   (w_sb_eff)
  );

  // x0 is never pending, so the rd!=0 guard only matters for clarity of the
  // WAW term; the read terms are safe against x0 without it.
  assign w_hazard = (dec_rs1_used_i & w_sb_eff[dec_rs1_addr_i])
                  | (dec_rs2_used_i & w_sb_eff[dec_rs2_addr_i])
                  | (dec_rd_write_i & (dec_rd_addr_i != 5'd0) & w_sb_eff[dec_rd_addr_i]);

  assign w_taken  = branch_i & exm_out_valid_i;

  // The instruction in decode during a taken cycle is on the wrong path, so
  // it neither issues nor claims its destination.
  assign w_issue  = rst_i & dec_valid_i & exm_ready_i & ~w_hazard & ~w_taken
                  & (r_state == HZD_RUN);

  // ---------------------------------------------------------------------------
  // Flush FSM: a taken branch in either state (re)loads the counter, so a
  // second branch during a flush restarts the full FLUSH_LEN window.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= HZD_RUN;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    flush_o     = 1'b0;
    exm_valid_o = w_issue;
    dec_stall_o = ~rst_i | (dec_valid_i & ~w_issue);
    unique case (r_state)
      HZD_RUN: begin
        if (w_taken) begin
          w_state_nxt = HZD_FLUSH;
          w_cnt_nxt   = CNT_RELOAD;
        end
      end
      HZD_FLUSH: begin
        flush_o = 1'b1;
        if (w_taken) begin
          w_cnt_nxt = CNT_RELOAD;
        end else if (r_cnt == 4'd0) begin
          w_state_nxt = HZD_RUN;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = HZD_RUN;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

`ifdef HZD_PERF_COUNTERS_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters. Every taken branch outside reset is
  // either a RUN->FLUSH entry or a reload, so both are counted by w_taken.
  // ---------------------------------------------------------------------------
  logic [31:0] r_stall_count;
  logic [31:0] r_flush_count;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (dec_valid_i && dec_stall_o && (r_stall_count != 32'hFFFF_FFFF)) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
      if (w_taken && (r_flush_count != 32'hFFFF_FFFF)) begin
        r_flush_count <= r_flush_count + 32'd1;
      end
    end
  end

  assign stall_count_o = r_stall_count;
  assign flush_count_o = r_flush_count;
`endif

endmodule : hzd

// File: tb/tb_hzd.sv
// -----------------------------------------------------------------------------
// tb_hzd
// Directed bench for hzd with FLUSH_LEN=2. A table of per-cycle input records
// with hand-computed outputs covers reset, RAW/WAW stalls, writeback bypass,
// x0 handling, ready back-pressure and a single flush; hand-written sequences
// cover a flush reload and reset in the middle of a flush.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hzd;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        dec_valid_i;
  logic        dec_rs1_used_i;
  logic [4:0]  dec_rs1_addr_i;
  logic        dec_rs2_used_i;
  logic [4:0]  dec_rs2_addr_i;
  logic        dec_rd_write_i;
  logic [4:0]  dec_rd_addr_i;
  logic        exm_ready_i;
  logic        exm_valid_o;
  logic        dec_stall_o;
  logic        branch_i;
  logic        exm_out_valid_i;
  logic        wb_write_i;
  logic [4:0]  wb_addr_i;
  logic        flush_o;
`ifdef HZD_PERF_COUNTERS_EN
  logic [31:0] stall_count_o;
  logic [31:0] flush_count_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  hzd #(.FLUSH_LEN(2)) u_dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .dec_valid_i     (dec_valid_i),
    .dec_rs1_used_i  (dec_rs1_used_i),
    .dec_rs1_addr_i  (dec_rs1_addr_i),
    .dec_rs2_used_i  (dec_rs2_used_i),
    .dec_rs2_addr_i  (dec_rs2_addr_i),
    .dec_rd_write_i  (dec_rd_write_i),
    .dec_rd_addr_i   (dec_rd_addr_i),
    .exm_ready_i     (exm_ready_i),
    .exm_valid_o     (exm_valid_o),
    .dec_stall_o     (dec_stall_o),
    .branch_i        (branch_i),
    .exm_out_valid_i (exm_out_valid_i),
    .wb_write_i      (wb_write_i),
    .wb_addr_i       (wb_addr_i),
    .flush_o         (flush_o)
`ifdef HZD_PERF_COUNTERS_EN
    ,
    .stall_count_o   (stall_count_o),
    .flush_count_o   (flush_count_o)
`endif
  );

  typedef struct packed {
    logic       rst;
    logic       dv;
    logic       r1u;
    logic [4:0] r1;
    logic       r2u;
    logic [4:0] r2;
    logic       rdw;
    logic [4:0] rd;
    logic       rdy;
    logic       br;
    logic       bv;
    logic       wbw;
    logic [4:0] wba;
    logic       ev;   // expected exm_valid_o
    logic       es;   // expected dec_stall_o
    logic       ef;   // expected flush_o
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  function automatic vec_t v(input logic dv,
                             input logic r1u, input logic [4:0] r1,
                             input logic r2u, input logic [4:0] r2,
                             input logic rdw, input logic [4:0] rd,
                             input logic wbw, input logic [4:0] wba,
                             input logic br,  input logic bv,
                             input logic ev,  input logic es, input logic ef);
    vec_t t;
    t.rst = 1'b1; t.rdy = 1'b1;
    t.dv = dv; t.r1u = r1u; t.r1 = r1; t.r2u = r2u; t.r2 = r2;
    t.rdw = rdw; t.rd = rd; t.wbw = wbw; t.wba = wba;
    t.br = br; t.bv = bv; t.ev = ev; t.es = es; t.ef = ef;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t t);
    rst_i           = t.rst;
    dec_valid_i     = t.dv;
    dec_rs1_used_i  = t.r1u;
    dec_rs1_addr_i  = t.r1;
    dec_rs2_used_i  = t.r2u;
    dec_rs2_addr_i  = t.r2;
    dec_rd_write_i  = t.rdw;
    dec_rd_addr_i   = t.rd;
    exm_ready_i     = t.rdy;
    branch_i        = t.br;
    exm_out_valid_i = t.bv;
    wb_write_i      = t.wbw;
    wb_addr_i       = t.wba;
  endtask

  task automatic idle();
    drive(v(0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0,0));
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later,
  // well before the next edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic es, input logic ef);
    #1;
    check({tag, ".exm_valid"}, {31'd0, exm_valid_o}, {31'd0, ev});
    check({tag, ".dec_stall"}, {31'd0, dec_stall_o}, {31'd0, es});
    check({tag, ".flush"},     {31'd0, flush_o},     {31'd0, ef});
  endtask

`ifdef HZD_PERF_COUNTERS_EN
  logic [31:0] flush_base;
`endif

  initial begin
    //                dv r1u r1  r2u r2  rdw rd  wbw wba br bv  ev es ef
    vecs[0]  = v(1, 0,0,  0,0,  0,0,  0,0,  0,0, 0,1,0); // in reset
    vecs[1]  = v(0, 0,0,  0,0,  0,0,  0,0,  0,0, 0,0,0); // idle, no stall
    vecs[2]  = v(1, 0,0,  0,0,  1,5,  0,0,  0,0, 1,0,0); // issue rd=5
    vecs[3]  = v(1, 1,5,  0,0,  0,0,  0,0,  0,0, 0,1,0); // RAW on x5
    vecs[4]  = v(1, 1,5,  0,0,  0,0,  1,5,  0,0, 1,0,0); // wb x5 bypass
    vecs[5]  = v(1, 1,5,  0,0,  0,0,  0,0,  0,0, 1,0,0); // x5 retired
    vecs[6]  = v(1, 0,0,  0,0,  1,0,  0,0,  0,0, 1,0,0); // rd=x0
    vecs[7]  = v(1, 1,0,  1,0,  1,0,  0,0,  0,0, 1,0,0); // read/write x0
    vecs[8]  = v(1, 0,0,  0,0,  1,7,  0,0,  0,0, 1,0,0); // issue rd=7
    vecs[9]  = v(1, 0,0,  0,0,  1,7,  1,7,  0,0, 1,0,0); // set+clr x7
    vecs[10] = v(1, 0,0,  1,7,  0,0,  0,0,  0,0, 0,1,0); // rs2=7 stalls
    vecs[11] = v(1, 0,0,  0,0,  1,9,  0,0,  0,0, 0,1,0); // not ready
    vecs[12] = v(1, 0,0,  0,0,  1,9,  1,7,  0,0, 1,0,0); // x9 untouched
    vecs[13] = v(1, 1,9,  0,0,  0,0,  1,9,  0,0, 1,0,0); // bypass x9
    vecs[14] = v(1, 0,0,  0,0,  1,12, 0,0,  0,0, 1,0,0); // issue rd=12
    vecs[15] = v(1, 0,0,  0,0,  1,12, 0,0,  0,0, 0,1,0); // WAW x12
    vecs[16] = v(1, 0,0,  0,0,  1,12, 1,12, 0,0, 1,0,0); // WAW bypass
    vecs[17] = v(0, 0,0,  0,0,  0,0,  1,12, 0,0, 0,0,0); // retire x12
    vecs[18] = v(1, 0,0,  0,0,  1,3,  0,0,  1,1, 0,1,0); // taken, suppress
    vecs[19] = v(1, 0,0,  0,0,  1,3,  0,0,  0,0, 0,1,1); // flush 1
    vecs[20] = v(1, 0,0,  0,0,  1,3,  0,0,  0,0, 0,1,1); // flush 2
    vecs[21] = v(1, 1,3,  0,0,  0,0,  0,0,  0,0, 1,0,0); // x3 never set
    vecs[22] = v(1, 0,0,  0,0,  0,0,  0,0,  1,0, 1,0,0); // branch unqualified
    vecs[23] = v(0, 0,0,  0,0,  0,0,  0,0,  0,0, 0,0,0); // no flush
    vecs[0].rst  = 1'b0;
    vecs[11].rdy = 1'b0;

    // Two reset cycles so state is known before the first checked row.
    idle();
    rst_i = 1'b0;
    tick();
    tick();
    check("reset.sb_q", u_dut.u_sb.r_sb, 32'h0);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i]);
      check_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].es, vecs[i].ef);
      tick();
      if (i == 9) check("setwins.sb_q7", {31'd0, u_dut.u_sb.r_sb[7]}, 32'd1);
      if (i == 11) check("notready.sb_q9", {31'd0, u_dut.u_sb.r_sb[9]}, 32'd0);
    end
    check("table_end.sb_q", u_dut.u_sb.r_sb, 32'h0);

    // ---- Flush reload: second taken branch in first flush cycle ----------
`ifdef HZD_PERF_COUNTERS_EN
    flush_base = flush_count_o;
`endif
    drive(v(0, 0,0, 0,0, 0,0, 0,0, 1,1, 0,0,0));
    check_outs("reload.taken", 0, 0, 0);
    tick();
    drive(v(1, 0,0, 0,0, 0,0, 0,0, 1,1, 0,1,1));
    check_outs("reload.f1", 0, 1, 1);
    tick();
    drive(v(1, 0,0, 0,0, 0,0, 0,0, 0,0, 0,1,1));
    check_outs("reload.f2", 0, 1, 1);
    tick();
    check_outs("reload.f3", 0, 1, 1);
    tick();
    check_outs("reload.run", 1, 0, 0);
`ifdef HZD_PERF_COUNTERS_EN
    check("reload.flush_count", flush_count_o - flush_base, 32'd2);
`endif
    idle();
    tick();

    // ---- Reset in the middle of a flush with x4..x7 pending --------------
    for (int r = 4; r <= 7; r++) begin
      drive(v(1, 0,0, 0,0, 1,5'(r), 0,0, 0,0, 1,0,0));
      check_outs($sformatf("fill.x%0d", r), 1, 0, 0);
      tick();
    end
    check("fill.sb_q", u_dut.u_sb.r_sb, 32'h0000_00F0);
    drive(v(0, 0,0, 0,0, 0,0, 0,0, 1,1, 0,0,0));
    tick();
    drive(v(1, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0,0));
    rst_i = 1'b0;
    check_outs("midflush.in_reset", 0, 1, 1);
    check("midflush.sb_kept", u_dut.u_sb.r_sb, 32'h0000_00F0);
    tick();
    drive(v(1, 1,4, 1,7, 1,4, 0,0, 0,0, 1,0,0));
    check_outs("after_reset.issue", 1, 0, 0);
    check("after_reset.sb_q", u_dut.u_sb.r_sb, 32'h0);
    tick();
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_hzd
